// File: rtl/raisin64_run_ctrl.sv
// Run controller for the raisin64 core: sequences core reset release, counts RUN
// cycles and ends a run on halt, PC stall or cycle-budget timeout.
module raisin64_run_ctrl #(
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned MAX_CYCLES   = 100,
   parameter int unsigned STALL_LIMIT  = 16,
   parameter int unsigned PC_W         = 64,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [PC_W-1:0]  cpu_pc,
   input  logic             cpu_halt,
   output logic             cpu_rst_n,
   output logic             running,
   output logic             done,
   output logic [1:0]       reason,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int unsigned STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

   localparam logic [RST_W-1:0]   RST_LAST     = RST_W'(RESET_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LIM_M1 = STALL_W'(STALL_LIMIT - 1);
   localparam logic [CNT_W-1:0]   MAX_M1       = CNT_W'(MAX_CYCLES - 1);

   localparam logic [1:0] REASON_NONE    = 2'd0;
   localparam logic [1:0] REASON_HALT    = 2'd1;
   localparam logic [1:0] REASON_STALL   = 2'd2;
   localparam logic [1:0] REASON_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [RST_W-1:0]   r_rst_cnt;
   logic [STALL_W-1:0] r_stall_cnt;
   logic [PC_W-1:0]    r_last_pc;
   logic [CNT_W-1:0]   r_cycle_count;
   logic [1:0]         r_reason;
   logic               r_cpu_rst_n;
   logic               w_cpu_rst_n_next;

   logic               w_rst_last;
   logic               w_pc_same;
   logic               w_halt_hit;
   logic               w_stall_hit;
   logic               w_timeout_hit;
   logic               w_end;
   logic [1:0]         w_end_reason;

   assign w_rst_last    = (r_rst_cnt == RST_LAST);
   assign w_pc_same     = (cpu_pc == r_last_pc);
   assign w_halt_hit    = cpu_halt;
   assign w_stall_hit   = (STALL_LIMIT != 0) && w_pc_same && (r_stall_cnt == STALL_LIM_M1);
   assign w_timeout_hit = (MAX_CYCLES != 0) && (r_cycle_count == MAX_M1);
   assign w_end         = w_halt_hit || w_stall_hit || w_timeout_hit;

   // Priority halt > stall > timeout when several end conditions hit together.
   always_comb begin
      w_end_reason = REASON_NONE;
      if (w_halt_hit)
         w_end_reason = REASON_HALT;
      else if (w_stall_hit)
         w_end_reason = REASON_STALL;
      else if (w_timeout_hit)
         w_end_reason = REASON_TIMEOUT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  w_state_next = run ? S_RESET : S_IDLE;
         S_RESET: w_state_next = !run ? S_IDLE : (w_rst_last ? S_RUN : S_RESET);
         S_RUN:   w_state_next = !run ? S_IDLE : (w_end ? S_DONE : S_RUN);
         S_DONE:  w_state_next = run ? S_DONE : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // The core sees reset released exactly while the next state is RUN.
   always_comb begin
      w_cpu_rst_n_next = (w_state_next == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rst_n   <= 1'b0;
         r_rst_cnt     <= '0;
         r_stall_cnt   <= '0;
         r_last_pc     <= '0;
         r_cycle_count <= '0;
         r_reason      <= REASON_NONE;
      end else begin
         r_cpu_rst_n <= w_cpu_rst_n_next;
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_cycle_count <= '0;
                  r_reason      <= REASON_NONE;
                  r_stall_cnt   <= '0;
                  r_rst_cnt     <= '0;
               end
            end
            S_RESET: begin
               if (run) begin
                  if (w_rst_last)
                     r_last_pc <= cpu_pc;
                  else
                     r_rst_cnt <= r_rst_cnt + RST_W'(1);
               end
            end
            S_RUN: begin
               if (run) begin
                  if (r_cycle_count != '1)
                     r_cycle_count <= r_cycle_count + CNT_W'(1);
                  if (w_pc_same) begin
                     if (STALL_LIMIT != 0)
                        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                  end else begin
                     r_stall_cnt <= '0;
                     r_last_pc   <= cpu_pc;
                  end
                  if (w_end)
                     r_reason <= w_end_reason;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu_rst_n   = r_cpu_rst_n;
   assign running     = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign reason      = r_reason;
   assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_raisin64_run_ctrl.sv
// Directed bench for raisin64_run_ctrl: default instance plus a MAX_CYCLES=0 /
// STALL_LIMIT=0 / 8-bit counter instance sharing the same stimulus.
module tb_raisin64_run_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [63:0] cpu_pc = 64'h0;
   logic        cpu_halt = 1'b0;

   logic        cpu_rst_n, running, done;
   logic [1:0]  reason;
   logic [31:0] cycle_count;

   logic        z_cpu_rst_n, z_running, z_done;
   logic [1:0]  z_reason;
   logic [7:0]  z_cycle_count;

   int tests = 0;
   int fails = 0;

   raisin64_run_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .run(run), .cpu_pc(cpu_pc), .cpu_halt(cpu_halt),
      .cpu_rst_n(cpu_rst_n), .running(running), .done(done),
      .reason(reason), .cycle_count(cycle_count)
   );

   raisin64_run_ctrl #(.MAX_CYCLES(0), .STALL_LIMIT(0), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .run(run), .cpu_pc(cpu_pc), .cpu_halt(cpu_halt),
      .cpu_rst_n(z_cpu_rst_n), .running(z_running), .done(z_done),
      .reason(z_reason), .cycle_count(z_cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a run from IDLE and checks the RESET window; returns right after the
   // edge that enters RUN, with r_last_pc loaded from pc0.
   task automatic start_run(input logic [63:0] pc0);
      cpu_pc = pc0;
      run = 1'b1;
      step();
      chk("rst_e1_cpu_rst_n", cpu_rst_n, 0);
      chk("rst_e1_count_clr", cycle_count, 0);
      chk("rst_e1_reason_clr", reason, 0);
      step();
      chk("rst_e2_cpu_rst_n", cpu_rst_n, 0);
      chk("rst_e2_running", running, 0);
      step();
      chk("rst_e3_cpu_rst_n", cpu_rst_n, 1);
      chk("rst_e3_running", running, 1);
   endtask

   initial begin
      #1;
      chk("por_cpu_rst_n", cpu_rst_n, 0);
      chk("por_running", running, 0);
      chk("por_done", done, 0);
      chk("por_reason", reason, 0);
      chk("por_count", cycle_count, 0);
      #12 rst_n = 1'b1;
      step();
      step();
      chk("idle_hold_running", running, 0);

      // Timeout after 100 RUN cycles with an incrementing PC
      $display("[TB] timeout run");
      start_run(64'h1000);
      for (int n = 1; n <= 99; n++) begin
         cpu_pc = 64'h1000 + 64'(4 * n);
         step();
      end
      chk("to_pre_running", running, 1);
      chk("to_pre_count", cycle_count, 99);
      cpu_pc = 64'h1000 + 64'd400;
      step();
      chk("to_done", done, 1);
      chk("to_reason", reason, 3);
      chk("to_count", cycle_count, 100);
      chk("to_cpu_rst_n", cpu_rst_n, 0);
      chk("to_running", running, 0);
      step();
      step();
      chk("to_hold_done", done, 1);
      chk("to_hold_count", cycle_count, 100);
      run = 1'b0;
      step();
      chk("to_idle_done", done, 0);
      chk("to_idle_reason", reason, 3);
      chk("to_idle_count", cycle_count, 100);

      // Halt on RUN cycle 37
      $display("[TB] halt run");
      start_run(64'h1000);
      for (int n = 1; n <= 36; n++) begin
         cpu_pc = 64'h1000 + 64'(4 * n);
         step();
      end
      cpu_halt = 1'b1;
      cpu_pc = 64'h1000 + 64'(4 * 37);
      step();
      cpu_halt = 1'b0;
      chk("halt_done", done, 1);
      chk("halt_reason", reason, 1);
      chk("halt_count", cycle_count, 37);
      chk("halt_cpu_rst_n", cpu_rst_n, 0);
      chk("halt_z_reason", z_reason, 1);
      run = 1'b0;
      step();

      // PC frozen at 0x40 from RUN cycle 10: 16th unchanged sample on cycle 26
      $display("[TB] stall run");
      start_run(64'h1000);
      for (int n = 1; n <= 25; n++) begin
         cpu_pc = (n < 10) ? 64'h1000 + 64'(4 * n) : 64'h40;
         step();
      end
      chk("stall_pre_running", running, 1);
      step();
      chk("stall_done", done, 1);
      chk("stall_reason", reason, 2);
      chk("stall_count", cycle_count, 26);
      run = 1'b0;
      step();

      // PC changes every 15th cycle: never a stall, ends on timeout
      $display("[TB] slow-pc run");
      start_run(64'h2000);
      for (int n = 1; n <= 100; n++) begin
         cpu_pc = 64'h2000 + 64'(4 * (n / 15));
         step();
      end
      chk("slowpc_done", done, 1);
      chk("slowpc_reason", reason, 3);
      chk("slowpc_count", cycle_count, 100);
      run = 1'b0;
      step();

      // Halt coinciding with timeout
      $display("[TB] halt+timeout run");
      start_run(64'h1000);
      for (int n = 1; n <= 100; n++) begin
         cpu_pc = 64'h1000 + 64'(4 * n);
         cpu_halt = (n == 100);
         step();
      end
      cpu_halt = 1'b0;
      chk("prio_halt_reason", reason, 1);
      chk("prio_halt_count", cycle_count, 100);
      run = 1'b0;
      step();

      // Stall completing on cycle 100 together with timeout
      $display("[TB] stall+timeout run");
      start_run(64'h1000);
      for (int n = 1; n <= 99; n++) begin
         cpu_pc = (n < 84) ? 64'h1000 + 64'(4 * n) : 64'h40;
         step();
      end
      chk("prio_stall_pre_running", running, 1);
      step();
      chk("prio_stall_reason", reason, 2);
      chk("prio_stall_count", cycle_count, 100);
      run = 1'b0;
      step();

      // Asynchronous reset in the middle of a run
      $display("[TB] async reset run");
      start_run(64'h1000);
      for (int n = 1; n <= 50; n++) begin
         cpu_pc = 64'h1000 + 64'(4 * n);
         step();
      end
      chk("ar_pre_count", cycle_count, 50);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cpu_rst_n", cpu_rst_n, 0);
      chk("ar_running", running, 0);
      chk("ar_done", done, 0);
      chk("ar_reason", reason, 0);
      chk("ar_count", cycle_count, 0);
      run = 1'b0;
      #2 rst_n = 1'b1;
      step();
      step();
      step();
      chk("ar_idle_running", running, 0);
      chk("ar_idle_cpu_rst_n", cpu_rst_n, 0);
      start_run(64'h1000);

      // Abort at RUN cycle 20, then restart
      $display("[TB] abort/restart run");
      for (int n = 1; n <= 20; n++) begin
         cpu_pc = 64'h1000 + 64'(4 * n);
         step();
      end
      run = 1'b0;
      step();
      chk("ab_running", running, 0);
      chk("ab_done", done, 0);
      chk("ab_reason", reason, 0);
      chk("ab_count", cycle_count, 20);
      chk("ab_cpu_rst_n", cpu_rst_n, 0);
      start_run(64'h1000);
      run = 1'b0;
      step();

      // Timeout and stall disabled: only halt ends the run; 8-bit count saturates
      $display("[TB] no-timeout/no-stall run");
      start_run(64'h40);
      for (int n = 1; n <= 200; n++)
         step();
      chk("z_mid_count", z_cycle_count, 200);
      chk("z_mid_running", z_running, 1);
      for (int n = 1; n <= 100; n++)
         step();
      chk("z_sat_count", z_cycle_count, 255);
      chk("z_sat_running", z_running, 1);
      chk("z_sat_done", z_done, 0);
      chk("z_sat_cpu_rst_n", z_cpu_rst_n, 1);
      cpu_halt = 1'b1;
      step();
      cpu_halt = 1'b0;
      chk("z_halt_done", z_done, 1);
      chk("z_halt_reason", z_reason, 1);
      chk("z_halt_count", z_cycle_count, 255);
      run = 1'b0;
      step();
      chk("z_idle_done", z_done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
